// File: rtl/can_rec_uplink_arbiter.sv
// Round-robin arbiter over the 32 CAN receive channels. The granted frame is
// captured into a small FWFT FIFO that feeds the elink uplink transmitter.
module can_rec_uplink_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MUX_LAT    = 1,
  parameter int unsigned CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       n_buses,
  input  logic [31:0]      irq_can_rec,
  input  logic [75:0]      data_rec_in,
  output logic [4:0]       can_rec_select,
  output logic [31:0]      irq_ack,
  output logic [75:0]      data_rec_uplink,
  output logic             uplink_valid,
  input  logic             uplink_ready,
  output logic             fifo_full,
  output logic [CNT_W-1:0] fifo_count,
  output logic             busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned WC_W  = $clog2(MUX_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_MUX, CAPTURE} state_e;

  state_e            state_q;
  logic [4:0]        sel_q;
  logic [4:0]        last_grant_q;
  logic [WC_W-1:0]   wcnt_q;
  logic [31:0]       ack_q;
  logic              busy_q;

  logic [75:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q;
  logic [75:0]       last_pop_q;

  logic [31:0]       elig;
  logic [4:0]        grant;
  logic [4:0]        idx;
  logic              found;
  logic              any_elig;
  logic              has_room;
  logic              push, pop;

  // Search starts one past the last grant, so last_grant itself is visited last.
  always_comb begin
    elig  = '0;
    grant = last_grant_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      elig[i] = irq_can_rec[i] & (i <= {27'd0, n_buses});
    end
    for (int unsigned k = 1; k <= 32; k++) begin
      idx = last_grant_q + 5'(k);
      if (!found && elig[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign any_elig = |elig;
  assign has_room = (count_q != CNT_W'(FIFO_DEPTH));
  assign push     = (state_q == CAPTURE);
  assign pop      = (count_q != '0) && uplink_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_grant_q <= '1;
      wcnt_q       <= '0;
      ack_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (any_elig && has_room) begin
            sel_q   <= grant;
            wcnt_q  <= WC_W'(MUX_LAT);
            state_q <= WAIT_MUX;
            busy_q  <= 1'b1;
          end
        end
        WAIT_MUX: begin
          if (!irq_can_rec[sel_q]) begin
            wcnt_q  <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (wcnt_q == WC_W'(1)) begin
            // Ack is registered here so it is high exactly during CAPTURE.
            wcnt_q  <= '0;
            ack_q   <= 32'd1 << sel_q;
            state_q <= CAPTURE;
          end else begin
            wcnt_q <= wcnt_q - WC_W'(1);
          end
        end
        CAPTURE: begin
          last_grant_q <= sel_q;
          state_q      <= IDLE;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= data_rec_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      last_pop_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
        last_pop_q <= mem[rd_ptr_q];
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
    end
  end

  // Once drained, the head output keeps showing the frame that left last.
  assign data_rec_uplink = (count_q != '0) ? mem[rd_ptr_q] : last_pop_q;
  assign uplink_valid    = (count_q != '0);
  assign fifo_count      = count_q;
  assign fifo_full       = full_q;
  assign can_rec_select  = sel_q;
  assign irq_ack         = ack_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_can_rec_uplink_arbiter.sv
// Scoreboard bench for can_rec_uplink_arbiter: directed scenarios followed by
// randomized request/backpressure traffic against a transaction-level model.
module tb_can_rec_uplink_arbiter;

  localparam int DEPTH   = 4;
  localparam int MUX_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  n_buses;
  logic [31:0] irq_can_rec;
  logic [75:0] data_rec_in;
  logic [4:0]  can_rec_select;
  logic [31:0] irq_ack;
  logic [75:0] data_rec_uplink;
  logic        uplink_valid;
  logic        uplink_ready;
  logic        fifo_full;
  logic [2:0]  fifo_count;
  logic        busy;

  can_rec_uplink_arbiter #(
    .FIFO_DEPTH(DEPTH),
    .MUX_LAT   (MUX_LAT),
    .CNT_W     (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .n_buses        (n_buses),
    .irq_can_rec    (irq_can_rec),
    .data_rec_in    (data_rec_in),
    .can_rec_select (can_rec_select),
    .irq_ack        (irq_ack),
    .data_rec_uplink(data_rec_uplink),
    .uplink_valid   (uplink_valid),
    .uplink_ready   (uplink_ready),
    .fifo_full      (fifo_full),
    .fifo_count     (fifo_count),
    .busy           (busy)
  );

  always #12 clk = ~clk;

  // Receive mux with one cycle of latency after can_rec_select.
  logic [75:0] frames [32];
  always @(posedge clk) data_rec_in <= frames[can_rec_select];

  int checks   = 0;
  int failures = 0;

  logic [75:0] sb[$];
  int          obs[$];
  int          exp_order[$];
  int          m_busy, m_sel, m_last, m_cnt;
  logic [31:0] cleared_now;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [31:0] el, input int last);
    for (int k = 1; k <= 32; k++) begin
      if (el[(last + k) % 32]) return (last + k) % 32;
    end
    return -1;
  endfunction

  function automatic logic [31:0] eligible();
    logic [31:0] e;
    for (int i = 0; i < 32; i++) e[i] = irq_can_rec[i] && (i <= int'(n_buses));
    return e;
  endfunction

  // m_busy counts remaining cycles of the in-flight transaction (1 = capture cycle).
  task automatic model_step();
    int g;
    bit pop;
    pop = (m_cnt > 0) && uplink_ready;
    if (m_busy == 0) begin
      g = rr_pick(eligible(), m_last);
      if (g >= 0 && m_cnt < DEPTH) begin
        m_sel  = g;
        m_busy = MUX_LAT + 1;
      end
    end else if (m_busy == 1) begin
      sb.push_back(frames[m_sel]);
      m_last = m_sel;
      m_busy = 0;
      m_cnt++;
    end else begin
      if (!irq_can_rec[m_sel]) m_busy = 0;
      else m_busy--;
    end
    if (pop) m_cnt--;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("select", can_rec_select, m_sel);
    check("busy", busy, m_busy != 0);
    check("irq_ack", irq_ack, (m_busy == 1) ? (32'd1 << m_sel) : 32'd0);
    check("fifo_count", fifo_count, m_cnt);
    check("fifo_full", fifo_full, m_cnt == DEPTH);
    check("uplink_valid", uplink_valid, m_cnt != 0);
    for (int i = 0; i < 32; i++) begin
      if (irq_ack[i]) begin
        obs.push_back(i);
        break;
      end
    end
    cleared_now = '0;
    if (m_busy == 1) begin
      irq_can_rec[m_sel] = 1'b0;
      cleared_now[m_sel] = 1'b1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check("reset_select", can_rec_select, 0);
    check("reset_ack", irq_ack, 0);
    check("reset_data", data_rec_uplink, 0);
    check("reset_valid", uplink_valid, 0);
    check("reset_full", fifo_full, 0);
    check("reset_count", fifo_count, 0);
    check("reset_busy", busy, 0);
    irq_can_rec = '0;
    m_busy = 0;
    m_sel  = 0;
    m_last = 31;
    m_cnt  = 0;
    sb.delete();
    obs.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_order(input string name);
    check({name, "_len"}, obs.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < obs.size(); i++) check(name, obs[i], exp_order[i]);
  endtask

  task automatic raise(input int b);
    frames[b] = 76'({$urandom(), $urandom(), $urandom()});
    irq_can_rec[b] = 1'b1;
  endtask

  // Head frame must match the oldest expected entry whenever it is presented.
  always @(negedge clk) begin
    if (rst && uplink_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("valid_without_frame", uplink_valid, 0);
      end else begin
        check("head_data", data_rec_uplink, sb[0]);
        if (uplink_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bit slow;
    int b;
    irq_can_rec  = '0;
    n_buses      = 5'd31;
    uplink_ready = 1'b1;
    cleared_now  = '0;
    foreach (frames[i]) frames[i] = '0;
    #5;
    apply_reset();

    // Single frame on bus 3, then the head output holds it after draining.
    frames[3] = 76'h0_DEAD_BEEF_0000_0123;
    irq_can_rec[3] = 1'b1;
    run(8);
    exp_order = '{3};
    check_order("t1_order");
    check("t1_hold_last", data_rec_uplink, 76'h0_DEAD_BEEF_0000_0123);

    // Round robin from reset, then wrap after last_grant=31.
    apply_reset();
    raise(0); raise(5); raise(31);
    run(15);
    raise(0); raise(5);
    run(10);
    exp_order = '{0, 5, 31, 0, 5};
    check_order("t2_order");

    // Masking by n_buses.
    apply_reset();
    n_buses = 5'd4;
    raise(2); raise(7);
    run(12);
    exp_order = '{2};
    check_order("t3_masked");
    n_buses = 5'd31;
    run(8);
    exp_order = '{2, 7};
    check_order("t3_unmasked");

    // Backpressure: FIFO fills at DEPTH, then drains in grant order.
    apply_reset();
    uplink_ready = 1'b0;
    for (int i = 0; i < 6; i++) raise(i);
    run(20);
    check("t4_count", fifo_count, 4);
    check("t4_full", fifo_full, 1);
    exp_order = '{0, 1, 2, 3};
    check_order("t4_blocked");
    uplink_ready = 1'b1;
    run(30);
    exp_order = '{0, 1, 2, 3, 4, 5};
    check_order("t4_drained");

    // Request withdrawn during the mux wait.
    apply_reset();
    raise(9);
    cycle();
    irq_can_rec[9] = 1'b0;
    run(6);
    exp_order.delete();
    check_order("t5_no_ack");
    check("t5_count", fifo_count, 0);

    // Reset while waiting on the mux with two frames buffered.
    apply_reset();
    uplink_ready = 1'b0;
    raise(1); raise(2);
    run(8);
    raise(3);
    cycle();
    check("t6_busy_before_reset", busy, 1);
    check("t6_count_before_reset", fifo_count, 2);
    apply_reset();
    uplink_ready = 1'b1;
    raise(7); raise(0);
    run(8);
    exp_order = '{0, 7};
    check_order("t6_after_reset");

    // Randomized traffic.
    apply_reset();
    slow = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) slow = ~slow;
      uplink_ready = slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        b = $urandom_range(0, 31);
        if (!irq_can_rec[b] && !cleared_now[b]) raise(b);
      end
      if ($urandom_range(0, 63) == 0) n_buses = 5'($urandom_range(0, 31));
      cycle();
    end
    n_buses = 5'd31;
    uplink_ready = 1'b1;
    run(200);
    check("drain_count", fifo_count, 0);
    check("drain_scoreboard", sb.size(), 0);
    check("drain_requests", irq_can_rec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_rec_uplink_arbiter.md
Name: can_rec_uplink_arbiter

Overview:
- Sits between the 32 CAN bus receive channels and the elink uplink transmitter inside mopshub_top_32bus.
- Arbitrates per-bus "frame received" requests with a round-robin pointer and drives can_rec_select to the receive data mux.
- Captures the selected 76-bit frame into a small first-word-fall-through (FWFT) FIFO.
- Presents frames to the elink uplink over a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, uplink frame buffer depth; power of 2, minimum 2
MUX_LAT, 1, cycles from can_rec_select change to valid data_rec_in; minimum 1
CNT_W, 3, fifo_count width, equal to log2(FIFO_DEPTH)+1

Ports:
clk  in  1  system clock, 40 MHz
rst  in  1  asynchronous, active-low reset
n_buses  in  5  highest enabled bus index; bus i is eligible iff i <= n_buses
irq_can_rec  in  32  per-bus request level; held high by the bus until acknowledged
data_rec_in  in  76  frame from the receive mux, indexed by can_rec_select
can_rec_select  out  5  bus currently selected at the receive mux
irq_ack  out  32  one-hot, single-cycle acknowledge to the granted bus
data_rec_uplink  out  76  FIFO head frame
uplink_valid  out  1  FIFO not empty
uplink_ready  in  1  elink transmitter accepts the head frame
fifo_full  out  1  FIFO count equals FIFO_DEPTH
fifo_count  out  CNT_W  number of frames stored
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM in IDLE; FIFO empty; last_grant=31, so the first search starts at bus 0; wait counter cleared.
- Eligible request set: irq_can_rec[i] & (i <= n_buses). n_buses is sampled every cycle.
- Round-robin grant: first eligible index at or after (last_grant+1) mod 32, wrapping at 31→0.
  - Masked indices are skipped.
  - A request equal to last_grant is granted only if no other eligible request exists.
- FSM states: IDLE, WAIT_MUX, CAPTURE.
- IDLE:
  - If any eligible request exists and fifo_count < FIFO_DEPTH: register can_rec_select=grant, load wait counter with MUX_LAT, go to WAIT_MUX.
  - Otherwise stay in IDLE; can_rec_select holds its last value.
- WAIT_MUX:
  - Decrement the counter each cycle; go to CAPTURE when it reaches 0. This gives exactly MUX_LAT cycles in WAIT_MUX.
  - If irq_can_rec[can_rec_select] drops in any WAIT_MUX cycle: abort, no FIFO write, no ack, last_grant unchanged, go to IDLE.
- CAPTURE (one cycle):
  - Write data_rec_in into the FIFO.
  - irq_ack[can_rec_select]=1 for this single cycle.
  - last_grant=can_rec_select; go to IDLE.
- Throughput: one frame per MUX_LAT+2 cycles; the request is first visible in IDLE.
- No drop: only one capture is in flight and it is granted only when count < FIFO_DEPTH. Pops can only free space, so a capture never overflows.
- FIFO (FWFT):
  - data_rec_uplink = head entry; uplink_valid = (count != 0).
  - Pop when uplink_valid & uplink_ready.
  - Simultaneous push and pop: count unchanged, both take effect.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - data_rec_uplink is stable while uplink_valid & !uplink_ready.
  - When empty, data_rec_uplink holds the last popped value (0 after reset).
- fifo_full and fifo_count are registered and update in the cycle after a push or pop.
- Reset mid-operation: any in-flight grant is discarded with no ack, and FIFO contents are lost.
- A change of n_buses while in WAIT_MUX does not abort the capture.
- Bus-side contract: a bus must deassert its request within 1 cycle after irq_ack. A request still high 2 cycles after ack is treated as a new frame.

Test Plan:
- Single frame: rst released, irq_can_rec[3]=1, data_rec_in=76'h0_DEAD_BEEF_0000_0123 when select=3, uplink_ready=1 → can_rec_select=3; irq_ack[3] pulses MUX_LAT+1 cycles after the request is seen; uplink_valid=1 with that data one cycle later.
- Round robin: bits 0, 5 and 31 held high, each cleared on ack, uplink_ready=1 → grant order 0, 5, 31. Then re-raise 0 and 5 with last_grant=31 → order 0, 5.
- Masking: n_buses=4, requests on 2 and 7 → only bus 2 acknowledged, bus 7 never selected. Then set n_buses=31 → bus 7 is granted next.
- Backpressure: uplink_ready=0, 6 requests on buses 0–5 → 4 captures, fifo_full=1, fifo_count=4, bus 4 not acked. Raise uplink_ready → frames drain in grant order and buses 4 and 5 are then captured.
- Withdrawn request: irq_can_rec[9] pulses for 1 cycle only → FSM returns to IDLE, no irq_ack, fifo_count stays 0.
- Reset mid-op: assert rst=0 during WAIT_MUX with 2 frames buffered → all outputs 0 immediately. After release, a request on bus 0 is granted first.
